sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO that is the next generation of the team's fixed 128x1024 buffer. Width and depth are configurable. It adds programmable almost-full and almost-empty thresholds, an exact fill-level output, a read-valid strobe, and sticky overflow/underflow error flags. It sits between a streaming producer and consumer in the same clock domain.

---
 rtl/sync_fifo_pkg.sv | 33 +++
 rtl/sync_fifo_ram.sv | 60 ++++++
 rtl/sync_fifo_param.sv | 175 +++++++++++++++++
 tb/tb_sync_fifo_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - sizing helpers and parameter legality checks for sync_fifo_param
//
// Purpose: shared constant functions used at elaboration time by sync_fifo_param.
//   ptr_width : bits needed to address DEPTH entries
//   cnt_width : bits needed to hold a fill level of 0..DEPTH inclusive
//   is_pow2   : power-of-two test for DEPTH
//   params_ok : full legality check of the FIFO parameter set
// Ports: none (package).

package sync_fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit over the pointer so that "full" is a distinct count value
  // and all DEPTH slots are usable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int dw, input int depth,
                                   input int af, input int ae);
    return (dw >= 1) && (depth >= 4) && is_pow2(depth) &&
           (af >= 1) && (af <= depth - 1) &&
           (ae >= 0) && (ae <= depth - 2);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - simple dual-port storage array for sync_fifo_param
//
// Purpose: DATA_WIDTH x DEPTH memory, one write port and one read port.
//   Default build: read data is registered (1-cycle latency), the read
//   register resets to zero.
//   SYNC_FIFO_FWFT_EN defined: read data is a combinational lookup of
//   rd_addr_i, so the head entry is visible without a read strobe.
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset (read register only)
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read strobe (registered-read build only)
//   rd_addr_i  read address
//   rd_data_o  read data
// Storage contents are never reset.

module sync_fifo_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_rd_ctrl;
  assign unused_rd_ctrl = rd_en_i ^ reset;
  assign rd_data_o      = mem_q[rd_addr_i];
`else
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds and sticky errors
//
// Purpose: single-clock FIFO between a streaming producer and consumer.
//   Exact fill level, programmable almost-full/almost-empty, read-valid
//   strobe, sticky overflow/underflow flags with synchronous clear.
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   undefined : 1-cycle registered read, o_rdvalid pulses per accepted read
//   defined   : first-word-fall-through, o_rddata shows the head entry and
//               o_rdvalid = !o_empty; i_rden pops the head
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-high reset
//   i_wren          write request
//   i_wrdata        write data
//   i_rden          read request (pop acknowledge in FWFT mode)
//   i_clr_err       synchronous clear of the sticky error flags
//   o_rddata        read data
//   o_rdvalid       o_rddata valid this cycle
//   o_full          count == DEPTH
//   o_empty         count == 0
//   o_almost_full   count >= AF_THRESH
//   o_almost_empty  count <= AE_THRESH
//   o_count         fill level 0..DEPTH
//   o_overflow      sticky: write attempted while full
//   o_underflow     sticky: read attempted while empty

module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1024,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_wren,
  input  logic [DATA_WIDTH-1:0]  i_wrdata,
  input  logic                   i_rden,
  input  logic                   i_clr_err,
  output logic [DATA_WIDTH-1:0]  o_rddata,
  output logic                   o_rdvalid,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_almost_full,
  output logic                   o_almost_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  if (!params_ok(DATA_WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_param: illegal DATA_WIDTH/DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_accept;
  logic          rd_accept;
  logic          full;
  logic          empty;

  // Flags decode straight from the registered count, so they line up with
  // o_count in the same cycle.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A pop frees the slot this cycle, so a write at full is taken when paired
  // with a read. An empty FIFO never bypasses write data to the read side.
  assign rd_accept = i_rden && !empty;
  assign wr_accept = i_wren && (!full || rd_accept);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear first, then a same-cycle error re-sets the flag.
    if (i_clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (i_wren && !wr_accept) begin
      ovf_d = 1'b1;
    end
    if (i_rden && empty) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  logic [DATA_WIDTH-1:0] ram_rd_data;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (i_wrdata),
    .rd_en_i   (rd_accept),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rddata  = ram_rd_data;
  assign o_rdvalid = !empty;
`else
  logic rdvalid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdvalid_q <= 1'b0;
    end else begin
      rdvalid_q <= rd_accept;
    end
  end

  assign o_rddata  = ram_rd_data;
  assign o_rdvalid = rdvalid_q;
`endif

  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (count_q >= AF_CNT);
  assign o_almost_empty = (count_q <= AE_CNT);
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param (registered-read build)

module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wren;
  logic [DW-1:0] wrdata;
  logic          rden;
  logic          clr_err;
  logic [DW-1:0] rddata;
  logic          rdvalid;
  logic          full, empty, afull, aempty, ovf, udf;
  logic [4:0]    count;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of stored words plus the visible output state.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_rddata;
  logic          m_rdvalid;
  logic          m_ovf;
  logic          m_udf;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_wren         (wren),
    .i_wrdata       (wrdata),
    .i_rden         (rden),
    .i_clr_err      (clr_err),
    .o_rddata       (rddata),
    .o_rdvalid      (rdvalid),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (afull),
    .o_almost_empty (aempty),
    .o_count        (count),
    .o_overflow     (ovf),
    .o_underflow    (udf)
  );

  function automatic logic [5:0] exp_flags();
    int sz = m_q.size();
    return {sz == DEPTH, sz == 0, sz >= AF, sz <= AE, m_ovf, m_udf};
  endfunction

  function automatic logic [5:0] dut_flags();
    return {full, empty, afull, aempty, ovf, udf};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rddata  = '0;
    m_rdvalid = 1'b0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
  endtask

  // One clock cycle: drive requests, clock, then advance the model.
  // Entered and left at 1 time unit after a rising edge.
  task automatic cyc(input logic we, input logic [DW-1:0] wd,
                     input logic re, input logic clr);
    logic rd_ok, wr_ok;
    wren = we; wrdata = wd; rden = re; clr_err = clr;
    @(posedge clk);
    #1;
    wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
    rd_ok = re && (m_q.size() != 0);
    wr_ok = we && ((m_q.size() < DEPTH) || rd_ok);
    m_rdvalid = rd_ok;
    if (rd_ok) m_rddata = m_q.pop_front();
    if (wr_ok) m_q.push_back(wd);
    if (we && !wr_ok) m_ovf = 1'b1;
    else if (clr)     m_ovf = 1'b0;
    if (re && !rd_ok) m_udf = 1'b1;
    else if (clr)     m_udf = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wren = 1'b0; wrdata = '0; rden = 1'b0; clr_err = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    total++;
    if (dut_flags() !== 6'b010100) begin
      bad++; $display("FAIL reset_flags got=%b exp=%b", dut_flags(), 6'b010100);
    end
    total++;
    if (count !== 5'd0 || rdvalid !== 1'b0 || rddata !== 8'h00) begin
      bad++; $display("FAIL reset_outputs got count=%0d rdvalid=%b rddata=%h exp 0/0/00",
                      count, rdvalid, rddata);
    end
    reset = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      total++;
      if (count !== 5'(i + 1) || dut_flags() !== exp_flags()) begin
        bad++; $display("FAIL fill_step%0d got count=%0d flags=%b exp count=%0d flags=%b",
                        i, count, dut_flags(), i + 1, exp_flags());
      end
    end
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    total++;
    if (count !== 5'd16 || ovf !== 1'b1 || full !== 1'b1) begin
      bad++; $display("FAIL fill_overflow got count=%0d ovf=%b full=%b exp 16/1/1",
                      count, ovf, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (rdvalid !== 1'b1 || rddata !== DW'(i) || count !== 5'(DEPTH - 1 - i) ||
          dut_flags() !== exp_flags()) begin
        bad++; $display("FAIL drain_step%0d got v=%b d=%h count=%0d flags=%b exp v=1 d=%h count=%0d flags=%b",
                        i, rdvalid, rddata, count, dut_flags(), DW'(i), DEPTH - 1 - i, exp_flags());
      end
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (rdvalid !== 1'b0 || udf !== 1'b1 || count !== 5'd0 || rddata !== 8'h0F) begin
      bad++; $display("FAIL drain_underflow got v=%b udf=%b count=%0d d=%h exp 0/1/0/0f",
                      rdvalid, udf, count, rddata);
    end
  endtask

  task automatic test_clear();
    cyc(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (ovf !== 1'b0 || udf !== 1'b0) begin
      bad++; $display("FAIL clear_both got ovf=%b udf=%b exp 0/0", ovf, udf);
    end
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    total++;
    if (ovf !== 1'b1 || udf !== 1'b0 || count !== 5'd16) begin
      bad++; $display("FAIL clear_vs_overflow got ovf=%b udf=%b count=%0d exp 1/0/16",
                      ovf, udf, count);
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
      total++;
      if (count !== 5'd16 || ovf !== 1'b0 || rdvalid !== 1'b1 || rddata !== m_rddata) begin
        bad++; $display("FAIL simul_full%0d got count=%0d ovf=%b v=%b d=%h exp 16/0/1/%h",
                        i, count, ovf, rdvalid, rddata, m_rddata);
      end
    end
    while (m_q.size() != 0) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    total++;
    if (count !== 5'd1 || udf !== 1'b1 || rdvalid !== 1'b0 || dut_flags() !== exp_flags()) begin
      bad++; $display("FAIL simul_empty got count=%0d udf=%b v=%b flags=%b exp 1/1/0/%b",
                      count, udf, rdvalid, dut_flags(), exp_flags());
    end
    cyc(1'b0, '0, 1'b1, 1'b1);
    total++;
    if (rddata !== 8'h5A || rdvalid !== 1'b1 || udf !== 1'b0) begin
      bad++; $display("FAIL simul_empty_data got d=%h v=%b udf=%b exp 5a/1/0", rddata, rdvalid, udf);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0));
      if (count !== 5'(m_q.size()) || dut_flags() !== exp_flags() ||
          rdvalid !== m_rdvalid || rddata !== m_rddata) begin
        errs++;
        $display("FAIL random_cyc%0d got count=%0d flags=%b v=%b d=%h exp count=%0d flags=%b v=%b d=%h",
                 i, count, dut_flags(), rdvalid, rddata, m_q.size(), exp_flags(), m_rdvalid, m_rddata);
      end
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL random_summary got mismatches=%0d exp 0", errs);
    end
  endtask

  task automatic test_reset_mid();
    while (m_q.size() != 0) cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (count !== 5'd9 || rdvalid !== 1'b1) begin
      bad++; $display("FAIL rstmid_setup got count=%0d v=%b exp 9/1", count, rdvalid);
    end
    reset = 1'b1;
    model_reset();
    #3;
    total++;
    if (empty !== 1'b1 || count !== 5'd0 || rdvalid !== 1'b0 || dut_flags() !== exp_flags()) begin
      bad++; $display("FAIL rstmid_async got empty=%b count=%0d v=%b flags=%b exp 1/0/0/%b",
                      empty, count, rdvalid, dut_flags(), exp_flags());
    end
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (rddata !== 8'hA5 || rdvalid !== 1'b1 || count !== 5'd0) begin
      bad++; $display("FAIL rstmid_a5 got d=%h v=%b count=%0d exp a5/1/0", rddata, rdvalid, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_clear();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
